// File: rtl/gpu_cmd_pkg.sv
// Shared command-stream definitions: header field layout, opcode constants
// and the parser state encoding.
package gpu_cmd_pkg;

    localparam logic [7:0] OP_NOP = 8'h00;

    localparam int HDR_OP_MSB  = 31;
    localparam int HDR_OP_LSB  = 24;
    localparam int HDR_LEN_MSB = 15;
    localparam int HDR_LEN_LSB = 0;

    typedef enum logic [0:0] {
        HDR = 1'b0,
        PAY = 1'b1
    } parse_state_e;

    function automatic logic [7:0] hdr_opcode(input logic [31:0] word);
        return word[HDR_OP_MSB:HDR_OP_LSB];
    endfunction

    function automatic logic [15:0] hdr_len(input logic [31:0] word);
        return word[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

endpackage

// File: rtl/cmd_skid2.sv
// Two-entry skid buffer for FIFO read data. An empty buffer presents the
// incoming word directly at its head so a word can be consumed on arrival.
module cmd_skid2 #(
    parameter int BW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [BW-1:0] push_data,
    input  logic          pop,
    output logic          head_valid,
    output logic [BW-1:0] head_data,
    output logic [1:0]    count
);

    logic [BW-1:0] mem_r [2];
    logic          wr_ptr_r;
    logic          rd_ptr_r;
    logic [1:0]    count_r;

    // Storage, pointers and occupancy; a push with a same-cycle pop on an
    // empty buffer advances both pointers and leaves the count at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_valid = (count_r != 2'd0) || push;
    assign head_data  = (count_r == 2'd0) ? push_data : mem_r[rd_ptr_r];
    assign count      = count_r;

endmodule

// File: rtl/cmd_parser.sv
// Command stream parser: pops header/payload words from the command FIFO and
// emits one output beat per payload word (or per header-only command).
module cmd_parser
    import gpu_cmd_pkg::*;
#(
    parameter int BW   = 32,
    parameter int LENW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          fifo_empty,
    input  logic [BW-1:0] fifo_q,
    output logic          fifo_rdreq,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_opcode,
    output logic [BW-1:0] out_data,
    output logic          out_first,
    output logic          out_last,
    output logic [15:0]   cmd_count
);

    parse_state_e   state_r;
    parse_state_e   state_next_s;
    logic [LENW-1:0] remaining_r;
    logic [LENW-1:0] remaining_next_s;
    logic [7:0]     opcode_r;
    logic [7:0]     opcode_next_s;
    logic           first_pend_r;
    logic           first_pend_next_s;

    logic           inflight_r;
    logic           rdreq_s;
    logic [1:0]     skid_count_s;
    logic           head_valid_s;
    logic [BW-1:0]  head_data_s;
    logic           pop_s;
    logic           consume_en_s;
    logic           accept_s;

    logic           load_s;
    logic [7:0]     beat_op_s;
    logic           beat_first_s;
    logic           beat_last_s;

    logic           out_valid_r;
    logic [7:0]     out_opcode_r;
    logic [BW-1:0]  out_data_r;
    logic           out_first_r;
    logic           out_last_r;
    logic [15:0]    cmd_count_r;

    // Request must see the live empty flag, so it cannot be registered.
    assign rdreq_s = !reset && !fifo_empty &&
                     (({1'b0, skid_count_s} + {2'b00, inflight_r}) < 3'd2);
    assign fifo_rdreq = rdreq_s;

    // Tracks the single read whose data appears on fifo_q next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= rdreq_s;
        end
    end

    cmd_skid2 #(.BW(BW)) u_skid (
        .clock      (clock),
        .reset      (reset),
        .push       (inflight_r),
        .push_data  (fifo_q),
        .pop        (pop_s),
        .head_valid (head_valid_s),
        .head_data  (head_data_s),
        .count      (skid_count_s)
    );

    assign accept_s     = out_valid_r && out_ready;
    assign consume_en_s = !out_valid_r || out_ready;
    assign pop_s        = head_valid_s && consume_en_s;

    // Parser FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= HDR;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and beat formation for the word at the skid head.
    always_comb begin
        state_next_s      = state_r;
        remaining_next_s  = remaining_r;
        opcode_next_s     = opcode_r;
        first_pend_next_s = first_pend_r;
        load_s            = 1'b0;
        beat_op_s         = opcode_r;
        beat_first_s      = 1'b0;
        beat_last_s       = 1'b0;
        if (pop_s) begin
            case (state_r)
                HDR: begin
                    if (hdr_opcode(head_data_s) == OP_NOP) begin
                        state_next_s = HDR;
                    end else if (hdr_len(head_data_s) == 16'd0) begin
                        load_s       = 1'b1;
                        beat_op_s    = hdr_opcode(head_data_s);
                        beat_first_s = 1'b1;
                        beat_last_s  = 1'b1;
                    end else begin
                        opcode_next_s     = hdr_opcode(head_data_s);
                        remaining_next_s  = LENW'(hdr_len(head_data_s));
                        first_pend_next_s = 1'b1;
                        state_next_s      = PAY;
                    end
                end
                PAY: begin
                    load_s            = 1'b1;
                    beat_first_s      = first_pend_r;
                    beat_last_s       = (remaining_r == LENW'(1));
                    remaining_next_s  = remaining_r - LENW'(1);
                    first_pend_next_s = 1'b0;
                    if (remaining_r == LENW'(1)) begin
                        state_next_s = HDR;
                    end else begin
                        state_next_s = PAY;
                    end
                end
                default: begin
                    state_next_s = HDR;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Command context plus output beat register; beat fields only change
    // when a new beat is loaded, which keeps them stable under backpressure.
    always_ff @(posedge clock) begin
        if (reset) begin
            remaining_r  <= '0;
            opcode_r     <= 8'h00;
            first_pend_r <= 1'b0;
            out_valid_r  <= 1'b0;
            out_opcode_r <= 8'h00;
            out_data_r   <= '0;
            out_first_r  <= 1'b0;
            out_last_r   <= 1'b0;
            cmd_count_r  <= 16'd0;
        end else begin
            remaining_r  <= remaining_next_s;
            opcode_r     <= opcode_next_s;
            first_pend_r <= first_pend_next_s;
            if (consume_en_s) begin
                out_valid_r <= load_s;
                if (load_s) begin
                    out_opcode_r <= beat_op_s;
                    out_data_r   <= head_data_s;
                    out_first_r  <= beat_first_s;
                    out_last_r   <= beat_last_s;
                end
            end
            if (accept_s && out_last_r) begin
                cmd_count_r <= cmd_count_r + 16'd1;
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign out_opcode = out_opcode_r;
    assign out_data   = out_data_r;
    assign out_first  = out_first_r;
    assign out_last   = out_last_r;
    assign cmd_count  = cmd_count_r;

endmodule

// File: tb/tb_cmd_parser.sv
// Randomized bench for cmd_parser: a queue-based FIFO model feeds commands,
// and expected beats are derived per command from the header rules.
module tb_cmd_parser;

    logic        clock = 1'b0;
    logic        reset;
    logic        fifo_empty;
    logic [31:0] fifo_q;
    logic        fifo_rdreq;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_opcode;
    logic [31:0] out_data;
    logic        out_first;
    logic        out_last;
    logic [15:0] cmd_count;

    always #5 clock = ~clock;

    cmd_parser #(.BW(32), .LENW(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .fifo_rdreq (fifo_rdreq),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_data   (out_data),
        .out_first  (out_first),
        .out_last   (out_last),
        .cmd_count  (cmd_count)
    );

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] data;
        logic        first;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] fifo_mem[$];
    logic [31:0] held[$];
    int          acc_cyc[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          exp_cmds = 0;
    int          lat_rd = -1;
    int          lat_valid = -1;
    bit          rdy_rand = 1'b0;
    bit          stall_rand = 1'b0;
    bit          prev_stall = 1'b0;
    beat_t       prev_snap;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Expected beats follow directly from the header: NOP -> none,
    // len 0 -> the header itself, otherwise one beat per payload word.
    task automatic push_cmd(input logic [7:0] op, input logic [7:0] rsv,
                            input logic [15:0] len, input logic [31:0] base);
        logic [31:0] hdr;
        logic [31:0] w;
        beat_t       b;
        hdr = {op, rsv, len};
        fifo_mem.push_back(hdr);
        if (op == 8'h00) return;
        if (len == 16'd0) begin
            b = '{op: op, data: hdr, first: 1'b1, last: 1'b1};
            exp_q.push_back(b);
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                w = base + 32'(i) * 32'h0101_0101;
                fifo_mem.push_back(w);
                b = '{op: op, data: w, first: (i == 0), last: (i == int'(len) - 1)};
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic step();
        beat_t snap;
        beat_t e;
        bit    rd;
        @(negedge clock);
        out_ready  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        fifo_empty = (fifo_mem.size() == 0) || (stall_rand && ($urandom_range(0, 3) == 0));
        #1;
        snap = '{op: out_opcode, data: out_data, first: out_first, last: out_last};
        if (!reset) begin
            if (fifo_empty) check("rdreq_while_empty", 64'(fifo_rdreq), 64'd0);
            if (prev_stall) check("hold_stable", 64'({out_valid, snap}), 64'({1'b1, prev_snap}));
            if (out_valid && lat_valid < 0) lat_valid = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(snap), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'(snap), 64'(e));
                    if (e.last) exp_cmds++;
                    acc_cyc.push_back(cyc);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_snap  = snap;
        end else begin
            prev_stall = 1'b0;
        end
        rd = fifo_rdreq && !fifo_empty;
        if (rd && lat_rd < 0) lat_rd = cyc;
        @(posedge clock);
        cyc++;
        #1;
        if (rd && fifo_mem.size() > 0) fifo_q = fifo_mem.pop_front();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fifo_mem.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_done", 64'(exp_q.size()), 64'd0);
        repeat (4) step();
        check("cmd_count", 64'(cmd_count), 64'(exp_cmds[15:0]));
    endtask

    task automatic check_reset_outs();
        check("reset_outs",
              64'({out_valid, out_first, out_last, fifo_rdreq, out_opcode, out_data, cmd_count}),
              64'd0);
    endtask

    initial begin
        int n;
        logic [7:0] op;
        reset      = 1'b1;
        fifo_empty = 1'b1;
        out_ready  = 1'b0;
        fifo_q     = 32'h0;
        repeat (3) step();
        check_reset_outs();
        reset = 1'b0;

        // Header-only command, latency rdreq -> out_valid
        lat_rd = -1;
        lat_valid = -1;
        push_cmd(8'h01, 8'h00, 16'd0, 32'h0);
        drain(50);
        check("latency", 64'(lat_valid - lat_rd), 64'd2);

        // Three-word payload back-to-back
        acc_cyc.delete();
        push_cmd(8'h02, 8'h00, 16'd3, 32'hA0A0_0001);
        drain(50);
        check("b2b_count", 64'(acc_cyc.size()), 64'd3);
        if (acc_cyc.size() == 3) check("b2b_gap", 64'(acc_cyc[2] - acc_cyc[0]), 64'd2);

        // NOP then header-only
        push_cmd(8'h00, 8'h00, 16'd0, 32'h0);
        push_cmd(8'h03, 8'h00, 16'd0, 32'h0);
        drain(50);

        // 16-word payload under random backpressure
        rdy_rand = 1'b1;
        push_cmd(8'h07, 8'h11, 16'd16, $urandom);
        drain(400);

        // FIFO runs dry after 2 of 5 payload words
        rdy_rand = 1'b0;
        push_cmd(8'h06, 8'h00, 16'd5, 32'h6000_0000);
        held.delete();
        repeat (3) held.push_front(fifo_mem.pop_back());
        n = 0;
        while (fifo_mem.size() != 0 && n < 50) begin
            step();
            n++;
        end
        check("fifo_ran_empty", 64'(fifo_mem.size()), 64'd0);
        repeat (10) step();
        check("stalled_beats_left", 64'(exp_q.size()), 64'd3);
        while (held.size() != 0) fifo_mem.push_back(held.pop_front());
        drain(100);

        // Random command stream with random stalls on both sides
        rdy_rand   = 1'b1;
        stall_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            op = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            push_cmd(op, 8'($urandom), 16'($urandom_range(0, 5)), $urandom);
        end
        drain(3000);

        // Reset in the middle of a payload
        rdy_rand   = 1'b0;
        stall_rand = 1'b0;
        push_cmd(8'h04, 8'h00, 16'd8, 32'h4000_0000);
        n = 0;
        while (exp_q.size() > 5 && n < 50) begin
            step();
            n++;
        end
        check("pre_reset_progress", 64'(exp_q.size()), 64'd5);
        reset = 1'b1;
        fifo_mem.delete();
        exp_q.delete();
        exp_cmds = 0;
        repeat (2) step();
        check_reset_outs();
        reset = 1'b0;
        acc_cyc.delete();
        push_cmd(8'h05, 8'h00, 16'd0, 32'h0);
        drain(50);
        check("post_reset_beats", 64'(acc_cyc.size()), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cmd_parser.md
CMD_PARSER -- requirements
Module: cmd_parser

Interface
REQ-001 Parameter BW, default 32, FIFO word width; SHALL be fixed at 32 by this revision.
REQ-002 Parameter LENW, default 16, width of the header length field and beat counter.
REQ-003 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 fifo_empty  in  1  upstream command FIFO empty flag.
REQ-006 fifo_q  in  32  upstream FIFO read data; valid the cycle after an accepted fifo_rdreq.
REQ-007 fifo_rdreq  out  1  pop request to the upstream FIFO.
REQ-008 out_valid  out  1  output beat valid.
REQ-009 out_ready  in  1  downstream accepts a beat when out_valid && out_ready.
REQ-010 out_opcode  out  8  opcode of the command the beat belongs to.
REQ-011 out_data  out  32  beat data.
REQ-012 out_first / out_last  out  1 each  first / last beat of a command.
REQ-013 cmd_count  out  16  number of completed non-NOP commands, wrapping mod 2^16.

Function
REQ-014 Header word format SHALL be: opcode = [31:24], reserved = [23:16] (ignored), len = [15:0] (payload word count).
REQ-015 fifo_rdreq SHALL assert only when !fifo_empty and (skid occupancy + reads in flight) < 2, so no returned word is ever dropped.
REQ-016 Each word on fifo_q SHALL be written into a 2-entry skid buffer in the cycle after its fifo_rdreq.
REQ-017 The parser FSM SHALL have states HDR and PAY, and SHALL consume the skid head only when the output register is empty or is being accepted that cycle.
REQ-018 HDR, opcode 0x00 (NOP): the word SHALL be discarded with no output beat, and the FSM SHALL remain in HDR.
REQ-019 HDR, len == 0, opcode != 0: SHALL emit one beat with out_data = header word and out_first = out_last = 1, then stay in HDR.
REQ-020 HDR, len > 0: SHALL latch opcode, load remaining = len, emit no beat, and go to PAY.
REQ-021 PAY: each payload word SHALL produce one beat with out_data = word and out_opcode = latched opcode.
REQ-022 PAY: out_first SHALL be set on the first payload beat only; out_last SHALL be set when remaining == 1, which also returns the FSM to HDR.
REQ-023 In PAY, remaining SHALL decrement once per consumed word; len = 0xFFFF SHALL be handled without overflow.
REQ-024 Output registers SHALL hold all values stable while out_valid && !out_ready.
REQ-025 cmd_count SHALL increment in the cycle the last beat of a command is accepted.
REQ-026 Latency from fifo_rdreq of a header-only command to its out_valid SHALL be 2 cycles.
REQ-027 With out_ready held high, throughput SHALL be 1 beat per cycle.
REQ-028 A fifo_empty assertion in mid-command SHALL stall the parser in PAY without losing position.

Reset
REQ-029 On reset: FSM = HDR; skid buffer empty; in-flight count = 0; remaining = 0; cmd_count = 0.
REQ-030 On reset: out_valid, out_first, out_last, fifo_rdreq = 0; out_opcode = 0; out_data = 0.
REQ-031 A read in flight when reset asserts SHALL be discarded.
REQ-032 Reset asserted mid-command SHALL abandon that command; the next word read after reset SHALL be treated as a header.

Structure
REQ-033 A shared gpu_cmd_pkg SHALL hold: opcode constants (OP_NOP = 8'h00), header field bit positions, and the state enum {HDR, PAY}.
REQ-034 The 2-entry skid buffer SHALL be a separate sub-module named cmd_skid2.
REQ-035 cmd_parser SHALL connect directly to the existing command FIFO (ports clock, rdreq, empty, q).

Verification
REQ-036 Header 0x01000000 alone, out_ready = 1 -> one beat: opcode 0x01, data 0x01000000, first = last = 1, cmd_count = 1.
REQ-037 Header 0x02000003 + payload A, B, C -> three beats with opcode 0x02; first on A only; last on C only; back-to-back.
REQ-038 Stream NOP, 0x03000000 -> NOP produces no beat; single beat for opcode 0x03; cmd_count = 1.
REQ-039 out_ready toggled randomly during a 16-word payload -> all 16 words in order, no drops or duplicates, outputs stable while stalled.
REQ-040 FIFO runs empty after 2 of 5 payload words, refilled 10 cycles later -> fifo_rdreq stays low while empty; remaining 3 beats resume, last beat correct.
REQ-041 Reset mid-payload of 0x04000008 -> all outputs reset; next word 0x05000000 emitted as a header-only command.
